// File: rtl/mem_arbiter.sv
// Memory arbiter. Two weight readers (rdn, dnn) and one result writer share
// a single memory port. Only one memory transaction is outstanding at a time.
// Requesters are served round-robin, and each transaction is bounded by a
// completion timeout.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdn_req,
    input  logic [ADDR_W-1:0] rdn_addr,
    output logic              rdn_rsp_vld,
    input  logic              dnn_req,
    input  logic [ADDR_W-1:0] dnn_addr,
    output logic              dnn_rsp_vld,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              mem_ready,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_write_done,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              err_timeout
);
    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RDN  = 2'd1,
        GNT_DNN  = 2'd2,
        GNT_WR   = 2'd3
    } gnt_t;

    state_t            state, state_next;
    gnt_t              grant_q, last_gnt, winner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] winner_addr;
    logic              rsp_cycle, do_grant, done, timed_out, txn_end;

    // Round-robin pick: the search starts at the requester after the last one granted.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        winner = GNT_NONE;
        case (last_gnt)
            GNT_RDN: begin
                if (dnn_req)      winner = GNT_DNN;
                else if (wr_req)  winner = GNT_WR;
                else if (rdn_req) winner = GNT_RDN;
            end
            GNT_DNN: begin
                if (wr_req)       winner = GNT_WR;
                else if (rdn_req) winner = GNT_RDN;
                else if (dnn_req) winner = GNT_DNN;
            end
            default: begin
                if (rdn_req)      winner = GNT_RDN;
                else if (dnn_req) winner = GNT_DNN;
                else if (wr_req)  winner = GNT_WR;
            end
        endcase
    end

    // Select the address of the winning requester.
    always_comb begin
        winner_addr = wr_addr;
        case (winner)
            GNT_RDN: winner_addr = rdn_addr;
            GNT_DNN: winner_addr = dnn_addr;
            default: winner_addr = wr_addr;
        endcase
    end

    // FSM next state plus grant, completion and timeout decisions.
    always_comb begin
        // A requester still holds its req during its response cycle, so no grant is made then.
        rsp_cycle  = rdn_rsp_vld | dnn_rsp_vld | wr_ack;
        do_grant   = (state == IDLE) && mem_ready && !rsp_cycle && (winner != GNT_NONE);
        done       = ((state == RD_WAIT) && mem_data_valid) ||
                     ((state == WR_WAIT) && mem_write_done);
        timed_out  = (state != IDLE) && !done && (wait_cnt == CNT_LAST);
        txn_end    = done || timed_out;
        state_next = state;
        case (state)
            IDLE:             if (do_grant) state_next = (winner == GNT_WR) ? WR_WAIT : RD_WAIT;
            RD_WAIT, WR_WAIT: if (txn_end)  state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
            state <= state_next;
        end
    end

    // Registered outputs: request pulses, latched address/data, wait counter, responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q     <= GNT_NONE;
            last_gnt    <= GNT_WR;      // rdn is searched first after reset
            wait_cnt    <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rsp_data    <= '0;
            rdn_rsp_vld <= 1'b0;
            dnn_rsp_vld <= 1'b0;
            wr_ack      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mem_rd_req  <= do_grant && (winner != GNT_WR);
            mem_wr_req  <= do_grant && (winner == GNT_WR);
            rdn_rsp_vld <= txn_end && (grant_q == GNT_RDN);
            dnn_rsp_vld <= txn_end && (grant_q == GNT_DNN);
            wr_ack      <= txn_end && (grant_q == GNT_WR);
            if (do_grant) begin
                grant_q  <= winner;
                last_gnt <= winner;
                mem_addr <= winner_addr;
                wait_cnt <= '0;
                if (winner == GNT_WR) mem_wdata <= wr_data;
            end else if (state != IDLE) begin
                if (txn_end) grant_q  <= GNT_NONE;
                else         wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (timed_out) err_timeout <= 1'b1;
            if ((state == RD_WAIT) && mem_data_valid) rsp_data <= mem_rdata;
        end
    end

    assign busy  = (state != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// random traffic. A transaction-level model is compared with the DUT every cycle.
module tb_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdn_req, dnn_req, wr_req;
    logic [ADDR_W-1:0] rdn_addr, dnn_addr, wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rdn_rsp_vld, dnn_rsp_vld, wr_ack;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_ready, mem_rd_req, mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid, mem_write_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy, err_timeout;
    logic [1:0]        grant;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .rdn_req(rdn_req), .rdn_addr(rdn_addr), .rdn_rsp_vld(rdn_rsp_vld),
        .dnn_req(dnn_req), .dnn_addr(dnn_addr), .dnn_rsp_vld(dnn_rsp_vld),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rsp_data(rsp_data), .mem_ready(mem_ready), .mem_rd_req(mem_rd_req),
        .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
        .mem_write_done(mem_write_done), .busy(busy), .grant(grant),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: who owns the memory port, for how long, and
    // which response pulse is due in the current cycle.
    int                m_owner, m_age, m_last, m_rsp;
    bit                m_issue, m_err;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_rsp_data;

    function automatic bit req_of(input int who);
        case (who)
            1:       return rdn_req;
            2:       return dnn_req;
            default: return wr_req;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(input int who);
        case (who)
            1:       return rdn_addr;
            2:       return dnn_addr;
            default: return wr_addr;
        endcase
    endfunction

    task automatic model_step();
        int nxt_rsp;
        int cand;
        bit nxt_issue;
        bit completed;
        if (rst) begin
            m_owner = 0; m_age = 0; m_last = 3; m_rsp = 0; m_issue = 0; m_err = 0;
            m_addr = '0; m_wdata = '0; m_rsp_data = '0;
            return;
        end
        nxt_rsp   = 0;
        nxt_issue = 0;
        if (m_owner == 0) begin
            if (m_rsp == 0 && mem_ready) begin
                for (int k = 1; k <= 3; k++) begin
                    cand = (m_last + k - 1) % 3 + 1;
                    if (m_owner == 0 && req_of(cand)) begin
                        m_owner   = cand;
                        m_last    = cand;
                        m_age     = 0;
                        m_addr    = addr_of(cand);
                        nxt_issue = 1;
                        if (cand == 3) m_wdata = wr_data;
                    end
                end
            end
        end else begin
            completed = (m_owner == 3) ? mem_write_done : mem_data_valid;
            if (completed) begin
                if (m_owner != 3) m_rsp_data = mem_rdata;
                nxt_rsp = m_owner;
                m_owner = 0;
            end else if (m_age + 1 == TIMEOUT) begin
                m_err   = 1;
                nxt_rsp = m_owner;
                m_owner = 0;
            end else begin
                m_age++;
            end
        end
        m_rsp   = nxt_rsp;
        m_issue = nxt_issue;
    endtask

    // Compare process: advance the model 1 time unit after each rising edge and compare with the DUT.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step();
            check("grant",       grant,       m_owner);
            check("busy",        busy,        m_owner != 0);
            check("mem_rd_req",  mem_rd_req,  m_issue && m_owner != 3);
            check("mem_wr_req",  mem_wr_req,  m_issue && m_owner == 3);
            check("mem_addr",    mem_addr,    m_addr);
            check("mem_wdata",   mem_wdata,   m_wdata);
            check("rdn_rsp_vld", rdn_rsp_vld, m_rsp == 1);
            check("dnn_rsp_vld", dnn_rsp_vld, m_rsp == 2);
            check("wr_ack",      wr_ack,      m_rsp == 3);
            check("rsp_data",    rsp_data,    m_rsp_data);
            check("err_timeout", err_timeout, m_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_busy();
        int n = 0;
        @(negedge clk);
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy", busy, 1'b1);
    endtask

    int exp_seq [4] = '{1, 2, 3, 1};
    int g;

    initial begin
        rst = 1'b1;
        rdn_req = 0; dnn_req = 0; wr_req = 0;
        rdn_addr = '0; dnn_addr = '0; wr_addr = '0; wr_data = '0;
        mem_ready = 1; mem_data_valid = 0; mem_write_done = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 2'd0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_rsp_data", rsp_data, 64'h0);
        rst = 1'b0;

        // Single read.
        @(negedge clk);
        rdn_req = 1; rdn_addr = 32'h40;
        @(negedge clk);
        check("rd_issue", mem_rd_req, 1'b1);
        check("rd_addr", mem_addr, 64'h40);
        check("rd_grant", grant, 2'd1);
        @(negedge clk);
        check("rd_pulse_once", mem_rd_req, 1'b0);
        repeat (3) @(negedge clk);
        mem_data_valid = 1; mem_rdata = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        mem_data_valid = 0;
        check("rd_rsp_vld", rdn_rsp_vld, 1'b1);
        check("rd_rsp_data", rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);
        check("rd_dnn_quiet", dnn_rsp_vld, 1'b0);
        rdn_req = 0;
        @(negedge clk);
        check("rd_rsp_once", rdn_rsp_vld, 1'b0);
        check("rd_idle", busy, 1'b0);

        // Round robin with all requesters held high.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rdn_req = 1; dnn_req = 1; wr_req = 1;
        rdn_addr = 32'h1000; dnn_addr = 32'h2000; wr_addr = 32'h3000; wr_data = 64'h0F0F;
        mem_rdata = 64'h1111_1111_1111_1111;
        for (int t = 0; t < 4; t++) begin
            wait_busy();
            check($sformatf("rr_grant_%0d", t), grant, exp_seq[t]);
            g = grant;
            repeat (2) @(negedge clk);
            if (g == 3) mem_write_done = 1;
            else        mem_data_valid = 1;
            @(negedge clk);
            mem_write_done = 0; mem_data_valid = 0;
            check($sformatf("rr_rdn_rsp_%0d", t), rdn_rsp_vld, exp_seq[t] == 1);
            check($sformatf("rr_dnn_rsp_%0d", t), dnn_rsp_vld, exp_seq[t] == 2);
            check($sformatf("rr_wr_ack_%0d", t), wr_ack, exp_seq[t] == 3);
            if (t == 3) begin
                rdn_req = 0; dnn_req = 0; wr_req = 0;
            end
        end
        @(negedge clk);

        // Write, with a spurious read completion while waiting.
        wr_req = 1; wr_addr = 32'h100; wr_data = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        check("wr_issue", mem_wr_req, 1'b1);
        check("wr_no_rd", mem_rd_req, 1'b0);
        check("wr_addr", mem_addr, 64'h100);
        check("wr_wdata", mem_wdata, 64'hDEAD_BEEF_0123_4567);
        check("wr_grant", grant, 2'd3);
        mem_data_valid = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        mem_data_valid = 0;
        check("wr_spur_busy", busy, 1'b1);
        check("wr_spur_rsp", rdn_rsp_vld | dnn_rsp_vld, 1'b0);
        check("wr_spur_data", rsp_data, 64'h1111_1111_1111_1111);
        mem_write_done = 1;
        @(negedge clk);
        mem_write_done = 0;
        check("wr_ack", wr_ack, 1'b1);
        check("wr_idle", busy, 1'b0);
        wr_req = 0;
        @(negedge clk);
        check("wr_ack_once", wr_ack, 1'b0);

        // Memory not ready holds the request pending.
        mem_ready = 0; dnn_req = 1; dnn_addr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("nr_busy", busy, 1'b0);
            check("nr_grant", grant, 2'd0);
        end
        mem_ready = 1;
        @(negedge clk);
        check("nr_grant_dnn", grant, 2'd2);
        mem_data_valid = 1; mem_rdata = 64'h2222_2222_2222_2222;
        @(negedge clk);
        mem_data_valid = 0;
        check("nr_dnn_rsp", dnn_rsp_vld, 1'b1);
        dnn_req = 0;
        @(negedge clk);

        // Timeout, then a normal transaction with the sticky flag still set.
        rdn_req = 1; rdn_addr = 32'h80;
        @(negedge clk);
        check("to_busy", busy, 1'b1);
        for (int k = 2; k <= TIMEOUT; k++) begin
            @(negedge clk);
            check($sformatf("to_wait_err_%0d", k), err_timeout, 1'b0);
            check($sformatf("to_wait_busy_%0d", k), busy, 1'b1);
        end
        @(negedge clk);
        check("to_err", err_timeout, 1'b1);
        check("to_rsp", rdn_rsp_vld, 1'b1);
        check("to_idle", busy, 1'b0);
        check("to_data_kept", rsp_data, 64'h2222_2222_2222_2222);
        rdn_req = 0;
        @(negedge clk);
        dnn_req = 1; dnn_addr = 32'h300;
        wait_busy();
        check("to_next_grant", grant, 2'd2);
        mem_data_valid = 1; mem_rdata = 64'h3333_3333_3333_3333;
        @(negedge clk);
        mem_data_valid = 0;
        check("to_next_rsp", dnn_rsp_vld, 1'b1);
        check("to_next_data", rsp_data, 64'h3333_3333_3333_3333);
        check("to_err_sticky", err_timeout, 1'b1);
        dnn_req = 0;
        @(negedge clk);

        // Reset in the middle of a read.
        rdn_req = 1; rdn_addr = 32'h44;
        @(negedge clk);
        check("mr_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mr_grant", grant, 2'd0);
        check("mr_busy0", busy, 1'b0);
        check("mr_err", err_timeout, 1'b0);
        check("mr_addr", mem_addr, 64'h0);
        check("mr_data", rsp_data, 64'h0);
        check("mr_rsp", rdn_rsp_vld, 1'b0);
        rdn_req = 0;
        @(negedge clk);
        rst = 1'b0;
        mem_data_valid = 1; mem_rdata = 64'h4444;
        @(negedge clk);
        mem_data_valid = 0;
        check("mr_late_rsp", rdn_rsp_vld, 1'b0);
        check("mr_late_data", rsp_data, 64'h0);
        @(negedge clk);
        check("mr_late_rsp2", rdn_rsp_vld, 1'b0);

        // Random traffic; each requester holds its request until its response pulse.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rdn_req && rdn_rsp_vld) rdn_req = 0;
            else if (!rdn_req && $urandom_range(0, 3) == 0) begin
                rdn_req = 1; rdn_addr = $urandom;
            end
            if (dnn_req && dnn_rsp_vld) dnn_req = 0;
            else if (!dnn_req && $urandom_range(0, 3) == 0) begin
                dnn_req = 1; dnn_addr = $urandom;
            end
            if (wr_req && wr_ack) wr_req = 0;
            else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1; wr_addr = $urandom; wr_data = {$urandom, $urandom};
            end
            mem_ready      = ($urandom_range(0, 3) != 0);
            mem_data_valid = ($urandom_range(0, 3) == 0);
            mem_write_done = ($urandom_range(0, 3) == 0);
            mem_rdata      = {$urandom, $urandom};
        end
        rdn_req = 0; dnn_req = 0; wr_req = 0;
        mem_data_valid = 0; mem_write_done = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 512, meaning memory line width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles to wait for memory completion.
REQ-004 The block SHALL have one clock and an asynchronous active-high reset; ports are clk (input, 1, rising-edge clock) and rst (input, 1, asynchronous active-high reset).
REQ-005 Requester ports SHALL be:
- rdn_req (input, 1): RDN weight read request.
- rdn_addr (input, ADDR_W): RDN read address.
- rdn_rsp_vld (output, 1): RDN read data valid.
- dnn_req (input, 1): DNN weight read request.
- dnn_addr (input, ADDR_W): DNN read address.
- dnn_rsp_vld (output, 1): DNN read data valid.
- wr_req (input, 1): result write request.
- wr_addr (input, ADDR_W): write address.
- wr_data (input, DATA_W): write line.
- wr_ack (output, 1): write complete.
- rsp_data (output, DATA_W): read line, shared by both readers.
REQ-006 Memory-side ports SHALL be:
- mem_ready (input, 1): memory buffer address valid.
- mem_rd_req (output, 1): read request pulse.
- mem_wr_req (output, 1): write request pulse.
- mem_addr (output, ADDR_W): request address.
- mem_wdata (output, DATA_W): write data.
- mem_data_valid (input, 1): read data returned.
- mem_rdata (input, DATA_W): read line.
- mem_write_done (input, 1): write complete.
REQ-007 Status ports SHALL be busy (output, 1), which is high whenever the state is not IDLE; grant (output, 2), which encodes 0=none, 1=rdn, 2=dnn, 3=wr; and err_timeout (output, 1), a sticky timeout flag.

Function
REQ-008 The FSM SHALL have three states, IDLE, RD_WAIT and WR_WAIT, and SHALL allow exactly one outstanding memory transaction.
REQ-009 In IDLE with mem_ready=1 and at least one request high, the block SHALL select a winner by round-robin, register its address (and wr_data for writes) into mem_addr/mem_wdata, set grant, and move to RD_WAIT (rdn/dnn) or WR_WAIT (wr) on the next edge.
REQ-010 Round-robin order SHALL be rdn->dnn->wr->rdn; search SHALL start at the requester after the last granted one; after reset, rdn has highest priority.
REQ-011 In IDLE with mem_ready=0, the block SHALL issue no grant and SHALL leave requests pending.
REQ-012 mem_rd_req or mem_wr_req SHALL pulse high for exactly the first cycle of RD_WAIT or WR_WAIT respectively, and SHALL be low at all other times.
REQ-013 Requesters SHALL hold req, addr and data stable until their response pulse; the arbiter SHALL sample them only in the IDLE grant cycle.
REQ-014 In RD_WAIT, on mem_data_valid=1 the block SHALL register mem_rdata into rsp_data, pulse the granted requester's rsp_vld for one cycle on the following cycle, and return to IDLE.
REQ-015 In WR_WAIT, on mem_write_done=1 the block SHALL pulse wr_ack for one cycle on the following cycle and return to IDLE.
REQ-016 The block SHALL ignore mem_data_valid in WR_WAIT and IDLE, and SHALL ignore mem_write_done in RD_WAIT and IDLE.
REQ-017 Request-to-grant latency SHALL be 1 cycle, and memory completion to response pulse SHALL be 1 cycle; after a response, a new grant SHALL be possible in the next cycle at the earliest, with no back-to-back grant in the response cycle.
REQ-018 A wait counter (clog2(TIMEOUT)+1 bits) SHALL clear on entering a wait state and increment each wait cycle; on reaching TIMEOUT, the block SHALL set err_timeout, return to IDLE, pulse the granted requester's response (rsp_data unchanged), and advance the round-robin pointer.
REQ-019 err_timeout SHALL clear only on reset.
REQ-020 rsp_data SHALL hold its last value between reads.

Reset
REQ-021 While rst=1, the block SHALL force: state=IDLE, grant=0, busy=0, err_timeout=0, all rsp_vld/wr_ack/mem_*_req=0, mem_addr=0, mem_wdata=0, rsp_data=0, counter=0, round-robin pointer=rdn-first.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction with no response pulse; the first grant after reset follows REQ-010.

Verification
REQ-023 Single read: rdn_req=1, rdn_addr=0x40, mem_data_valid after 5 cycles with mem_rdata=0xA5.. -> one-cycle mem_rd_req with mem_addr=0x40; rdn_rsp_vld one cycle later with rsp_data=0xA5..; dnn_rsp_vld stays 0.
REQ-024 All three requesters held high, memory completing each in 3 cycles -> grant sequence 1,2,3,1; each requester receives exactly one response per grant.
REQ-025 Write: wr_req=1, wr_addr=0x100, wr_data=pattern -> mem_wr_req pulse with mem_addr=0x100 and mem_wdata=pattern; wr_ack one cycle after mem_write_done; a spurious mem_data_valid during WR_WAIT has no effect.
REQ-026 mem_ready=0 with dnn_req=1 for 10 cycles -> no grant and busy=0; mem_ready rises -> grant=2 next cycle.
REQ-027 TIMEOUT=8, read with no completion -> err_timeout=1 after 8 wait cycles, rdn_rsp_vld pulse, state IDLE; next request is served normally with err_timeout still 1.
REQ-028 rst asserted in RD_WAIT, then deasserted -> all outputs zero, no rsp pulse; a later mem_data_valid is ignored.
